tqvp_prism_timers: RTL and testbench

Parametrised countdown-timer bank that sits beside the PRISM FSM controller inside the TinyQV peripheral. It generalises the fixed pair of preloadable counters to NUM_CNT counters of CNT_W bits. Each counter has per-channel auto-reload, sticky zero-event status with write-1-to-clear, and a maskable interrupt. The FSM drives load/decrement strobes and reads back the zero flags; the RISC-V core programs it over the peripheral bus.

---
 rtl/tqvp_prism_timers.sv | 143 ++++++++++++++
 tb/tb_tqvp_prism_timers.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_prism_timers.sv
// Countdown-timer bank for the PRISM peripheral: NUM_CNT preloadable
// counters with per-channel auto-reload, sticky zero events (W1C) and a
// maskable level interrupt, programmed over the TinyQV peripheral bus.

module tqvp_prism_timers_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  input  logic             ld_i,
  input  logic             dec_i,
  input  logic             arl_i,
  input  logic             pre_we_i,
  input  logic [CNT_W-1:0] pre_wd_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             evt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, pre_q;

  // Next count: halt freezes, load beats dec, the 1->0 step raises the event.
  always_comb begin
    cnt_d = cnt_q;
    evt_o = 1'b0;
    if (!halt_i) begin
      if (ld_i) begin
        cnt_d = pre_q;
      end else if (dec_i) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          evt_o = 1'b1;
          cnt_d = arl_i ? pre_q : '0;
        end
      end
    end
  end

  // Count and preload registers; a preload write never touches the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pre_we_i) pre_q <= pre_wd_i;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

module tqvp_prism_timers #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               halt,
  input  logic [NUM_CNT-1:0] load,
  input  logic [NUM_CNT-1:0] dec,
  output logic [NUM_CNT-1:0] zero,
  output logic               irq,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  output logic [31:0]        data_out
);
  logic                            wr32;
  logic [NUM_CNT-1:0][CNT_W-1:0]   count;
  logic [NUM_CNT-1:0]              evt;
  logic [NUM_CNT-1:0]              arl_q, arl_d, ien_q, ien_d, status_q, status_d, w1c;
  logic                            unused_bits;

  // Narrow bus writes are dropped entirely.
  assign wr32 = (data_write_n == 2'b10);

  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_lane
      tqvp_prism_timers_lane #(.CNT_W(CNT_W)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .halt_i   (halt),
        .ld_i     (load[g] & enable),
        .dec_i    (dec[g]),
        .arl_i    (arl_q[g]),
        .pre_we_i (wr32 && (address == 6'(4 * g))),
        .pre_wd_i (data_in[CNT_W-1:0]),
        .count_o  (count[g]),
        .zero_o   (zero[g]),
        .evt_o    (evt[g])
      );
    end
  endgenerate

  // CTRL/STATUS next state; a fresh event overrides a same-cycle clear.
  always_comb begin
    arl_d = arl_q;
    ien_d = ien_q;
    w1c   = '0;
    if (wr32 && address == 6'h20) begin
      arl_d = data_in[NUM_CNT-1:0];
      ien_d = data_in[8 +: NUM_CNT];
    end
    if (wr32 && address == 6'h24) w1c = data_in[NUM_CNT-1:0];
    status_d = (status_q & ~w1c) | evt;
  end

  // CTRL and STATUS registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arl_q    <= '0;
      ien_q    <= '0;
      status_q <= '0;
    end else begin
      arl_q    <= arl_d;
      ien_q    <= ien_d;
      status_q <= status_d;
    end
  end

  // Combinational read mux; unmapped addresses and unstored bits read 0.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (address == 6'(4 * i)) data_out[CNT_W-1:0] = count[i];
    end
    if (address == 6'h20) begin
      data_out[NUM_CNT-1:0]  = arl_q;
      data_out[8 +: NUM_CNT] = ien_q;
    end
    if (address == 6'h24) data_out[NUM_CNT-1:0] = status_q;
  end

  assign irq = |(status_q & ien_q);

  // Bus bits this configuration does not store.
  assign unused_bits = ^data_in;
endmodule

// File: tb/tb_tqvp_prism_timers.sv
// Bench for tqvp_prism_timers: directed vector table, reset/corner sequences,
// then randomized traffic against a behavioural model of the register map.

module tb_tqvp_prism_timers;
  localparam int N = 4;

  logic         clk = 1'b0, rst = 1'b1, enable = 1'b1, halt = 1'b0;
  logic [N-1:0] load = '0, dec = '0;
  logic [5:0]   address = '0;
  logic [31:0]  data_in = '0;
  logic [1:0]   data_write_n = 2'b11;
  logic [N-1:0] zero, zero8;
  logic         irq, irq8;
  logic [31:0]  data_out, data_out8;

  int total = 0, bad = 0;

  tqvp_prism_timers #(.NUM_CNT(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .load(load), .dec(dec),
    .zero(zero), .irq(irq), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_out(data_out));

  tqvp_prism_timers #(.NUM_CNT(N), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .halt(halt), .load(load), .dec(dec),
    .zero(zero8), .irq(irq8), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_out(data_out8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]   wa;
    logic [1:0]   wn;
    logic [31:0]  wd;
    logic [N-1:0] ld, dc;
    logic         en, hl;
    logic [5:0]   ra;
    logic [31:0]  exp_do;
    logic [N-1:0] exp_z;
    logic         exp_irq;
  } vec_t;

  function automatic vec_t v(input logic [5:0] wa, input logic [1:0] wn, input logic [31:0] wd,
                             input logic [N-1:0] ld, input logic [N-1:0] dc, input logic en,
                             input logic hl, input logic [5:0] ra, input logic [31:0] ed,
                             input logic [N-1:0] ez, input logic ei);
    vec_t r;
    r.wa = wa; r.wn = wn; r.wd = wd; r.ld = ld; r.dc = dc; r.en = en; r.hl = hl;
    r.ra = ra; r.exp_do = ed; r.exp_z = ez; r.exp_irq = ei;
    return r;
  endfunction

  // Behavioural model state
  int unsigned  mcnt[N], mpre[N];
  logic [N-1:0] marl, mien, mst;

  function automatic logic [31:0] mdl_read(input int a);
    if (a < 32 && a % 4 == 0 && a / 4 < N) return mcnt[a/4];
    if (a == 32) return (32'(mien) << 8) | 32'(marl);
    if (a == 36) return 32'(mst);
    return 0;
  endfunction

  function automatic logic [N-1:0] mdl_zero();
    logic [N-1:0] z;
    for (int i = 0; i < N; i++) z[i] = (mcnt[i] == 0);
    return z;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) begin mcnt[i] = 0; mpre[i] = 0; end
    marl = '0; mien = '0; mst = '0;
  endtask

  // One clock of the model, using the inputs currently driven.
  task automatic mdl_step();
    logic [N-1:0] ev = '0;
    int a = int'(address);
    for (int i = 0; i < N; i++) begin
      if (halt) continue;
      if (load[i] && enable) mcnt[i] = mpre[i];
      else if (dec[i] && mcnt[i] > 1) mcnt[i] = mcnt[i] - 1;
      else if (dec[i] && mcnt[i] == 1) begin
        ev[i] = 1'b1;
        mcnt[i] = marl[i] ? mpre[i] : 0;
      end
    end
    if (data_write_n == 2'b10) begin
      if (a < 32 && a % 4 == 0 && a / 4 < N) mpre[a/4] = data_in & 32'hFFFF;
      if (a == 32) begin marl = data_in[N-1:0]; mien = data_in[8 +: N]; end
      if (a == 36) mst = mst & ~data_in[N-1:0];
    end
    mst = mst | ev;
  endtask

  vec_t vt[$];

  initial begin
    // Reset state
    #12;
    chk("rst_zero", 32'(zero), 32'hF);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_cnt0", data_out, 0);
    address = 6'h20; #1 chk("rst_ctrl", data_out, 0);
    address = 6'h24; #1 chk("rst_status", data_out, 0);
    @(negedge clk); rst = 1'b0;
    cyc();

    vt.push_back(v(6'h00, 2'b10, 3, 0, 0, 1, 0, 6'h00, 0, 4'hF, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 0, 1, 0, 6'h00, 3, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 2, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 1, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h24, 1, 4'hF, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 0, 4'hF, 0));
    vt.push_back(v(6'h20, 2'b10, 32'h100, 0, 0, 1, 0, 6'h20, 32'h100, 4'hF, 1));
    vt.push_back(v(6'h24, 2'b10, 1, 0, 0, 1, 0, 6'h24, 0, 4'hF, 0));
    vt.push_back(v(6'h20, 2'b10, 32'h101, 0, 0, 1, 0, 6'h20, 32'h101, 4'hF, 0));
    vt.push_back(v(6'h00, 2'b10, 2, 0, 0, 1, 0, 6'h00, 0, 4'hF, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 0, 1, 0, 6'h00, 2, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 1, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 2, 4'hE, 1));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 1, 4'hE, 1));
    vt.push_back(v(6'h24, 2'b10, 1, 0, 1, 1, 0, 6'h24, 1, 4'hE, 1));
    vt.push_back(v(6'h24, 2'b10, 1, 0, 0, 1, 0, 6'h24, 0, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 1, 1, 0, 6'h00, 1, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 1, 1, 0, 6'h24, 0, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b10, 7, 1, 1, 1, 1, 6'h00, 2, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 0, 1, 0, 6'h00, 7, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b10, 9, 0, 0, 1, 0, 6'h00, 7, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 0, 0, 0, 6'h00, 7, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 1, 0, 1, 0, 6'h00, 9, 4'hE, 0));
    vt.push_back(v(6'h20, 2'b01, 0, 0, 0, 1, 0, 6'h20, 32'h101, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 0, 0, 1, 0, 6'h1C, 0, 4'hE, 0));
    vt.push_back(v(6'h04, 2'b10, 32'hFFFF_FF05, 0, 0, 1, 0, 6'h04, 0, 4'hE, 0));
    vt.push_back(v(6'h00, 2'b11, 0, 2, 0, 1, 0, 6'h04, 32'hFF05, 4'hC, 0));

    foreach (vt[k]) begin
      address = vt[k].wa; data_write_n = vt[k].wn; data_in = vt[k].wd;
      load = vt[k].ld; dec = vt[k].dc; enable = vt[k].en; halt = vt[k].hl;
      cyc();
      address = vt[k].ra; data_write_n = 2'b11; load = '0; dec = '0; enable = 1'b1; halt = 1'b0;
      #1;
      chk($sformatf("vec%0d_data", k), data_out, vt[k].exp_do);
      chk($sformatf("vec%0d_zero", k), 32'(zero), 32'(vt[k].exp_z));
      chk($sformatf("vec%0d_irq", k), 32'(irq), 32'(vt[k].exp_irq));
    end
    // Narrow counter keeps only the low preload byte.
    chk("w8_preload", data_out8, 32'h05);

    // Asynchronous reset in the middle of activity with irq pending
    address = 6'h20; data_in = 32'h0F0F; data_write_n = 2'b10; cyc();
    address = 6'h00; data_in = 1; cyc();
    data_write_n = 2'b11; load = 4'h1; cyc();
    load = '0; dec = 4'h1; cyc();
    dec = '0; #1;
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_cnt1", 32'(zero), 32'hC);
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt0", data_out, 0);
    chk("arst_zero", 32'(zero), 32'hF);
    chk("arst_irq", 32'(irq), 0);
    address = 6'h20; #1 chk("arst_ctrl", data_out, 0);
    address = 6'h24; #1 chk("arst_status", data_out, 0);
    @(negedge clk); rst = 1'b0;
    cyc();
    mdl_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      load   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      dec    = N'($urandom);
      halt   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        case ($urandom_range(0, 5))
          0, 1, 2, 3: begin address = 6'(4 * $urandom_range(0, 3)); data_in = $urandom_range(0, 4) | ($urandom & 32'hFFFF_0000); end
          4:          begin address = 6'h20; data_in = $urandom; end
          default:    begin address = 6'h24; data_in = $urandom; end
        endcase
        if (r == 0) data_write_n = 2'($urandom_range(0, 1));
        else        data_write_n = 2'b10;
      end else begin
        address = 6'($urandom_range(0, 63));
        data_in = $urandom;
        data_write_n = 2'b11;
      end
      #1;
      chk($sformatf("rnd%0d_data@%h", n, address), data_out, mdl_read(int'(address)));
      chk($sformatf("rnd%0d_zero", n), 32'(zero), 32'(mdl_zero()));
      chk($sformatf("rnd%0d_irq", n), 32'(irq), 32'(|(mst & mien)));
      @(posedge clk);
      mdl_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
